apb2axi_req_sched: RTL and testbench

//  Scheduler between the WR and RD request FIFOs (filled by the transaction manager) and the single
//  AXI issue port feeding the AW/AR channel drivers. Pops one request at a time and enforces
//  per-direction outstanding-transaction credits. Reads have priority; a write starvation limit

---
 rtl/apb2axi_req_sched.sv | 167 ++++++++++++++++
 tb/tb_apb2axi_req_sched.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb2axi_req_sched.sv
// ---------------------------------------------------------------------------
// apb2axi_req_sched
// Moves requests from the WR and RD request FIFOs onto the single AXI issue
// port that feeds the AW/AR channel drivers. It pops one request at a time and
// limits how many transactions of each direction can be outstanding at once.
// Reads take priority over writes. A starvation counter forces a write grant
// after STARVE_LIM consecutive read grants made while a write was eligible.
//
// Ports (all signals are in the aclk domain):
//   aclk, aresetn                   clock, asynchronous active-low reset
//   sched_enable                    allow new grants
//   wr_req_valid/data/pop           WR FIFO head and pop pulse
//   rd_req_valid/data/pop           RD FIFO head and pop pulse
//   iss_valid/ready/is_write/data   issue port handshake and payload
//   wr_done, rd_done                completion pulses that return credits
//   wr_outstanding, rd_outstanding  credits currently in use
//   cnt_err                         sticky flag: done pulse while count was 0
//   idle                            IDLE state with no transactions outstanding
//
// state | meaning
// IDLE  | arbitrate; a grant pops a FIFO head and captures it for issue
// ISSUE | hold the captured request on the issue port until iss_ready
// ---------------------------------------------------------------------------
module apb2axi_req_sched #(
    parameter int FIFO_ENTRY_W = 32,
    parameter int MAX_OUT_WR   = 4,
    parameter int MAX_OUT_RD   = 4,
    parameter int STARVE_LIM   = 8
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             sched_enable,
    input  logic                             wr_req_valid,
    input  logic [FIFO_ENTRY_W-1:0]          wr_req_data,
    output logic                             wr_req_pop,
    input  logic                             rd_req_valid,
    input  logic [FIFO_ENTRY_W-1:0]          rd_req_data,
    output logic                             rd_req_pop,
    output logic                             iss_valid,
    input  logic                             iss_ready,
    output logic                             iss_is_write,
    output logic [FIFO_ENTRY_W-1:0]          iss_data,
    input  logic                             wr_done,
    input  logic                             rd_done,
    output logic [$clog2(MAX_OUT_WR+1)-1:0]  wr_outstanding,
    output logic [$clog2(MAX_OUT_RD+1)-1:0]  rd_outstanding,
    output logic                             cnt_err,
    output logic                             idle
);

    localparam int WR_CW = $clog2(MAX_OUT_WR + 1);
    localparam int RD_CW = $clog2(MAX_OUT_RD + 1);
    localparam int SW    = $clog2(STARVE_LIM + 1);

    localparam logic [WR_CW-1:0] WR_MAX = WR_CW'(MAX_OUT_WR);
    localparam logic [RD_CW-1:0] RD_MAX = RD_CW'(MAX_OUT_RD);
    localparam logic [SW-1:0]    S_LIM  = SW'(STARVE_LIM);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [FIFO_ENTRY_W-1:0] iss_data_q;
    logic                    iss_is_write_q;
    logic [WR_CW-1:0]        wr_cnt_q;
    logic [RD_CW-1:0]        rd_cnt_q;
    logic [SW-1:0]           starve_q;
    logic                    cnt_err_q;

    logic wr_elig, rd_elig;
    logic grant_wr, grant_rd;
    logic wr_dec, rd_dec;

    // Eligibility is gated by aresetn so that a FIFO never sees a pop while
    // the scheduler is held in reset.
    always_comb begin
        wr_elig  = 1'b0;
        rd_elig  = 1'b0;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        state_d  = state_q;
        case (state_q)
            IDLE: begin
                wr_elig  = aresetn & sched_enable & wr_req_valid & (wr_cnt_q < WR_MAX);
                rd_elig  = aresetn & sched_enable & rd_req_valid & (rd_cnt_q < RD_MAX);
                grant_wr = wr_elig & (~rd_elig | (starve_q == S_LIM));
                grant_rd = rd_elig & ~grant_wr;
                if (grant_wr | grant_rd) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (iss_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A done pulse only returns a credit when one is actually in use.
    assign wr_dec = wr_done & (wr_cnt_q != '0);
    assign rd_dec = rd_done & (rd_cnt_q != '0);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= IDLE;
            iss_data_q     <= '0;
            iss_is_write_q <= 1'b0;
            wr_cnt_q       <= '0;
            rd_cnt_q       <= '0;
            starve_q       <= '0;
            cnt_err_q      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (grant_wr) begin
                iss_data_q     <= wr_req_data;
                iss_is_write_q <= 1'b1;
            end else if (grant_rd) begin
                iss_data_q     <= rd_req_data;
                iss_is_write_q <= 1'b0;
            end

            if (grant_wr) begin
                starve_q <= '0;
            end else if (grant_rd) begin
                if (!wr_elig) begin
                    starve_q <= '0;
                end else if (starve_q != S_LIM) begin
                    starve_q <= starve_q + 1'b1;
                end
            end

            // Credits are taken at grant time, so the cap holds even while a
            // request is still waiting on the issue port.
            case ({grant_wr, wr_dec})
                2'b10:   wr_cnt_q <= wr_cnt_q + 1'b1;
                2'b01:   wr_cnt_q <= wr_cnt_q - 1'b1;
                default: wr_cnt_q <= wr_cnt_q;
            endcase

            case ({grant_rd, rd_dec})
                2'b10:   rd_cnt_q <= rd_cnt_q + 1'b1;
                2'b01:   rd_cnt_q <= rd_cnt_q - 1'b1;
                default: rd_cnt_q <= rd_cnt_q;
            endcase

            if ((wr_done && wr_cnt_q == '0) || (rd_done && rd_cnt_q == '0)) begin
                cnt_err_q <= 1'b1;
            end
        end
    end

    assign wr_req_pop     = grant_wr;
    assign rd_req_pop     = grant_rd;
    assign iss_valid      = (state_q == ISSUE);
    assign iss_is_write   = iss_is_write_q;
    assign iss_data       = iss_data_q;
    assign wr_outstanding = wr_cnt_q;
    assign rd_outstanding = rd_cnt_q;
    assign cnt_err        = cnt_err_q;
    assign idle           = (state_q == IDLE) && (wr_cnt_q == '0) && (rd_cnt_q == '0);

endmodule

// File: tb/tb_apb2axi_req_sched.sv
// ---------------------------------------------------------------------------
// tb_apb2axi_req_sched
// Directed bench for the request scheduler. Queues model the WR/RD FIFOs; each
// request placed in a FIFO has its expected issue-port item pushed into a
// scoreboard queue, and every issue handshake pops and compares one item.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge or 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_apb2axi_req_sched;

    localparam int W = 32;

    logic          aclk;
    logic          aresetn;
    logic          sched_enable;
    logic          wr_req_valid;
    logic [W-1:0]  wr_req_data;
    logic          wr_req_pop;
    logic          rd_req_valid;
    logic [W-1:0]  rd_req_data;
    logic          rd_req_pop;
    logic          iss_valid;
    logic          iss_ready;
    logic          iss_is_write;
    logic [W-1:0]  iss_data;
    logic          wr_done;
    logic          rd_done;
    logic [2:0]    wr_outstanding;
    logic [2:0]    rd_outstanding;
    logic          cnt_err;
    logic          idle;

    apb2axi_req_sched #(
        .FIFO_ENTRY_W (W),
        .MAX_OUT_WR   (4),
        .MAX_OUT_RD   (4),
        .STARVE_LIM   (8)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .sched_enable   (sched_enable),
        .wr_req_valid   (wr_req_valid),
        .wr_req_data    (wr_req_data),
        .wr_req_pop     (wr_req_pop),
        .rd_req_valid   (rd_req_valid),
        .rd_req_data    (rd_req_data),
        .rd_req_pop     (rd_req_pop),
        .iss_valid      (iss_valid),
        .iss_ready      (iss_ready),
        .iss_is_write   (iss_is_write),
        .iss_data       (iss_data),
        .wr_done        (wr_done),
        .rd_done        (rd_done),
        .wr_outstanding (wr_outstanding),
        .rd_outstanding (rd_outstanding),
        .cnt_err        (cnt_err),
        .idle           (idle)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic [W-1:0] wq[$];
    logic [W-1:0] rq[$];
    logic [W:0]   exp_q[$];

    int n_total = 0;
    int n_pass  = 0;
    int n_wpop  = 0;
    int n_rpop  = 0;

    logic         auto_done = 1'b0;
    logic         saw_wpop  = 1'b0;
    logic         saw_rpop  = 1'b0;
    logic         prev_hold = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic         prev_dir  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic refresh();
        wr_req_valid = (wq.size() != 0);
        wr_req_data  = (wq.size() != 0) ? wq[0] : '0;
        rd_req_valid = (rq.size() != 0);
        rd_req_data  = (rq.size() != 0) ? rq[0] : '0;
    endtask

    task automatic push_wr(input logic [W-1:0] d);
        wq.push_back(d);
        exp_q.push_back({1'b1, d});
        refresh();
    endtask

    task automatic push_rd(input logic [W-1:0] d);
        rq.push_back(d);
        exp_q.push_back({1'b0, d});
        refresh();
    endtask

    // One clock: observe on the falling edge, then apply FIFO pops and done
    // pulses just after the rising edge.
    task automatic step();
        logic p_w, p_r, hs, hs_w;
        logic [W:0] e;
        @(negedge aclk);
        p_w  = wr_req_pop;
        p_r  = rd_req_pop;
        hs   = iss_valid && iss_ready;
        hs_w = iss_is_write;
        if (iss_valid) chk("no_pop_in_issue", {p_w, p_r}, 2'b00);
        if (prev_hold) begin
            chk("hold_data", iss_data, prev_data);
            chk("hold_dir", iss_is_write, prev_dir);
        end
        if (hs) begin
            chk("sb_nonempty", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("iss_item", {iss_is_write, iss_data}, e);
            end
        end
        prev_hold = iss_valid && !iss_ready;
        prev_data = iss_data;
        prev_dir  = iss_is_write;
        @(posedge aclk);
        #1;
        if (p_w && wq.size() != 0) void'(wq.pop_front());
        if (p_r && rq.size() != 0) void'(rq.pop_front());
        if (p_w) n_wpop++;
        if (p_r) n_rpop++;
        saw_wpop = p_w;
        saw_rpop = p_r;
        wr_done  = auto_done && hs && hs_w;
        rd_done  = auto_done && hs && !hs_w;
        refresh();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_rpop(input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!saw_rpop && k < 20);
        chk(tag, saw_rpop, 1'b1);
    endtask

    task automatic wait_wpop(input string tag);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!saw_wpop && k < 20);
        chk(tag, saw_wpop, 1'b1);
    endtask

    initial begin
        int p0, k;

        aresetn      = 1'b0;
        sched_enable = 1'b1;
        iss_ready    = 1'b0;
        wr_done      = 1'b0;
        rd_done      = 1'b0;
        rq.push_back(32'h99);
        wq.push_back(32'h98);
        refresh();

        // Reset state, with both FIFOs non-empty and scheduling enabled.
        #22;
        chk("rst_iss_valid", iss_valid, 1'b0);
        chk("rst_iss_is_write", iss_is_write, 1'b0);
        chk("rst_iss_data", iss_data, '0);
        chk("rst_wr_out", wr_outstanding, 3'd0);
        chk("rst_rd_out", rd_outstanding, 3'd0);
        chk("rst_cnt_err", cnt_err, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_pops", {wr_req_pop, rd_req_pop}, 2'b00);
        wq.delete();
        rq.delete();
        refresh();
        @(posedge aclk);
        #1;
        aresetn = 1'b1;

        // 1: single read and its latency.
        push_rd(32'hA5);
        wait_rpop("t1_pop");
        chk("t1_valid_next", iss_valid, 1'b1);
        chk("t1_is_write", iss_is_write, 1'b0);
        chk("t1_data", iss_data, 32'hA5);
        chk("t1_rd_out", rd_outstanding, 3'd1);
        iss_ready = 1'b1;
        step();
        chk("t1_valid_clear", iss_valid, 1'b0);
        rd_done = 1'b1;
        step();
        step();
        chk("t1_rd_out_ret", rd_outstanding, 3'd0);
        chk("t1_idle", idle, 1'b1);

        // 2: read credit cap.
        p0 = n_rpop;
        for (int i = 0; i < 6; i++) push_rd(32'h21 + i);
        steps(20);
        chk("t2_pops_cap", n_rpop - p0, 4);
        chk("t2_rd_out_cap", rd_outstanding, 3'd4);
        chk("t2_not_idle", idle, 1'b0);
        rd_done = 1'b1;
        steps(6);
        chk("t2_pops_after_done", n_rpop - p0, 5);
        chk("t2_rd_out_after_done", rd_outstanding, 3'd4);
        for (int i = 0; i < 5; i++) begin
            rd_done = 1'b1;
            steps(3);
        end
        chk("t2_pops_total", n_rpop - p0, 6);
        chk("t2_rd_out_drained", rd_outstanding, 3'd0);
        chk("t2_sb_empty", exp_q.size(), 0);

        // 3: starvation limit gives 8 reads then 1 write, repeating.
        auto_done    = 1'b1;
        sched_enable = 1'b0;
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < 8; i++) begin
                rq.push_back(32'h100 + g * 8 + i);
                exp_q.push_back({1'b0, 32'h100 + g * 8 + i});
            end
            wq.push_back(32'h200 + g);
            exp_q.push_back({1'b1, 32'h200 + g});
        end
        refresh();
        @(posedge aclk);
        #1;
        sched_enable = 1'b1;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            step();
            k++;
        end
        chk("t3_sb_drained", exp_q.size(), 0);
        steps(3);
        chk("t3_wr_out", wr_outstanding, 3'd0);
        chk("t3_rd_out", rd_outstanding, 3'd0);
        chk("t3_idle", idle, 1'b1);

        // 4: backpressure holds the request and blocks further pops.
        iss_ready = 1'b0;
        push_wr(32'h3C);
        wait_wpop("t4_wr_pop");
        push_rd(32'h77);
        p0 = n_rpop + n_wpop;
        steps(10);
        chk("t4_no_pops", n_rpop + n_wpop - p0, 0);
        chk("t4_valid_held", iss_valid, 1'b1);
        chk("t4_data_held", iss_data, 32'h3C);
        chk("t4_dir_held", iss_is_write, 1'b1);
        iss_ready = 1'b1;
        steps(6);
        chk("t4_sb_empty", exp_q.size(), 0);
        chk("t4_idle", idle, 1'b1);

        // 5: counter edges.
        auto_done = 1'b0;
        push_wr(32'h51);
        push_wr(32'h52);
        steps(6);
        chk("t5_wr_out_2", wr_outstanding, 3'd2);
        push_wr(32'h53);
        wr_done = 1'b1;
        step();
        chk("t5_coincident_pop", saw_wpop, 1'b1);
        chk("t5_wr_out_same", wr_outstanding, 3'd2);
        steps(2);
        wr_done = 1'b1;
        step();
        wr_done = 1'b1;
        step();
        chk("t5_wr_out_0", wr_outstanding, 3'd0);
        chk("t5_err_clear", cnt_err, 1'b0);
        wr_done = 1'b1;
        step();
        chk("t5_wr_out_floor", wr_outstanding, 3'd0);
        chk("t5_err_set", cnt_err, 1'b1);
        steps(3);
        chk("t5_err_sticky", cnt_err, 1'b1);
        chk("t5_sb_empty", exp_q.size(), 0);

        // 6: reset while a request is on the issue port.
        iss_ready = 1'b0;
        push_rd(32'h66);
        wait_rpop("t6_pop");
        chk("t6_in_issue", iss_valid, 1'b1);
        #2;
        aresetn = 1'b0;
        rq.push_back(32'h67);
        refresh();
        #1;
        chk("t6_valid_dropped", iss_valid, 1'b0);
        chk("t6_rd_out", rd_outstanding, 3'd0);
        chk("t6_wr_out", wr_outstanding, 3'd0);
        chk("t6_idle", idle, 1'b1);
        chk("t6_err_cleared", cnt_err, 1'b0);
        chk("t6_no_pop_in_reset", rd_req_pop, 1'b0);
        @(posedge aclk);
        #1;
        rq.delete();
        exp_q.delete();
        prev_hold = 1'b0;
        refresh();
        aresetn = 1'b1;
        step();
        chk("t6_idle_after", idle, 1'b1);
        chk("t6_valid_after", iss_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
